irq_req_queue: RTL and testbench
================================

# irq_req_queue

Buffers interrupt requests `{vec, fnc}` from user logic and issues them one at a time to the `gen_irq` trigger stage directly downstream. It holds each request stable until `gen_irq` reports ack, fail, or a response timeout. Failed requests are retried a bounded number of times and then dropped. Sent and dropped totals are exposed for status registers in the 250 MHz user box.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, minimum 2.
- `MAX_RETRY`, 3: re-issues allowed after the first failed attempt.
- `RETRY_GAP`, 16: idle cycles between a fail and the re-issue; minimum 1.
- `RESP_TIMEOUT`, 64: cycles allowed in `WAIT_RECV` or `WAIT_DONE` before the attempt counts as failed.

Ports. The single clock is `clk`; reset is `rstn`, asynchronous and active-low.
- `clk` in 1: clock.
- `rstn` in 1: asynchronous active-low reset.
- `req_vec` in 12: request vector.
- `req_fnc` in 8: request function.
- `req_vld` in 1: request valid.
- `req_rdy` out 1: request accepted when high together with `req_vld`.
- `vec` out 12: vector to `gen_irq`.
- `fnc` out 8: function to `gen_irq`.
- `trig` out 1: one-cycle issue pulse to `gen_irq`.
- `recv` in 1: from `gen_irq`; high while a request is in flight.
- `ack` in 1: from `gen_irq`; level, held until the next `trig`.
- `fail` in 1: from `gen_irq`; level, held until the next `trig`.
- `clr_cnt` in 1: synchronous clear of both counters.
- `level` out $clog2(DEPTH)+1: FIFO occupancy, including the head entry in flight.
- `busy` out 1: state is not `IDLE`.
- `cnt_sent` out 32: acknowledged requests.
- `cnt_drop` out 32: requests dropped after retries were exhausted.

## Operation
- **FIFO push.** A request is pushed when `req_vld && req_rdy`.
  - `req_rdy = !full`, combinational.
  - A push is refused when the FIFO is full, even if a pop occurs in the same cycle.
  - The head entry is popped only on final completion, never at issue.
- **FSM states:** `IDLE`, `ISSUE`, `WAIT_RECV`, `WAIT_DONE`, `BACKOFF`.
- **Transitions:**
  - `IDLE`: when the FIFO is not empty, latch the head into the `vec`/`fnc` registers, clear `retry_cnt`, go to `ISSUE`.
  - `ISSUE`: `trig` = 1 for this cycle only, go to `WAIT_RECV`.
  - `WAIT_RECV`: when `recv` = 1, go to `WAIT_DONE`. Stale `ack`/`fail` levels are ignored in this state.
  - `WAIT_DONE`: when `recv` = 0 and `ack` = 1, the attempt succeeded: pop, `cnt_sent`++, go to `IDLE`.
  - `WAIT_DONE`: when `recv` = 0 and `fail` = 1, the attempt failed.
  - If `ack` and `fail` are both high, `ack` wins.
  - **Timeout:** the timeout counter resets on entry to `WAIT_RECV`. When it reaches `RESP_TIMEOUT` in either wait state, the attempt counts as failed.
  - **Failed attempt:** if `retry_cnt < MAX_RETRY`, increment `retry_cnt` and go to `BACKOFF`. Otherwise pop, `cnt_drop`++, go to `IDLE`.
  - `BACKOFF`: count `RETRY_GAP` cycles, then go to `ISSUE`. `vec`/`fnc` are unchanged.
- **Output stability:** `vec`/`fnc` are stable from the `ISSUE` cycle until the state returns to `IDLE`.
- **Counters:**
  - Both counters saturate at 0xFFFF_FFFF.
  - `clr_cnt` zeroes both counters and wins over a same-cycle increment.
- **Reset** (asynchronous, any state):
  - FIFO emptied; any in-flight request is lost and not counted.
  - Output reset values: `trig`=0, `vec`=0, `fnc`=0, `busy`=0, `level`=0, `cnt_sent`=0, `cnt_drop`=0, `req_rdy`=1.
- **Pointer wrap:** FIFO pointers are $clog2(DEPTH)+1 bits. Full when the MSBs differ and the remaining bits are equal; empty when the pointers are equal.

## Timing
- **Issue latency:** a push accepted in cycle N into an empty, idle queue gives `trig` high in cycle N+2, with `vec`/`fnc` valid from N+2.
- **Back-to-back:** after completion in cycle M, the next `trig` is no earlier than M+2.
- **Retry spacing:** the fail is detected in cycle F; the re-issue `trig` occurs in cycle F+1+`RETRY_GAP`.
- **Timeout boundary:** `recv` never rises → the attempt fails `RESP_TIMEOUT` cycles after the `ISSUE` cycle.
- **Level update:** `level` updates on the cycle after a push or pop. A simultaneous push and pop leaves `level` unchanged.

## Structure
- Package `irq_req_pkg` holds:
  - `VEC_W`=12, `FNC_W`=8;
  - `irq_req_t` struct `{vec, fnc}`;
  - `irq_q_state_t` enum for the five states.
- Sub-module `irq_req_fifo`:
  - synchronous FIFO of `irq_req_t`;
  - asynchronous active-low reset;
  - outputs: `full`, `empty`, `level`, head data;
  - pop is controlled by the FSM.
- The top level contains the FSM, the retry/gap/timeout counters, and the status counters.

## Test plan
1. **Single request, prompt ack.** Push vec=0x005, fnc=0x01; model `recv` high for 3 cycles, then `ack`=1 → exactly one `trig` at N+2 with vec=0x005, fnc=0x01; `cnt_sent`=1; `level` back to 0.
2. **Full FIFO.** Push 9 requests back-to-back with `DEPTH`=8 and `recv` held low → `req_rdy`=0 after 8 accepts; 9th refused; `level`=8; all 8 later issued in push order.
3. **Retries exhausted.** `fail` on every attempt, `MAX_RETRY`=3, `RETRY_GAP`=16 → 4 `trig` pulses, each 17 cycles after the previous fail; `cnt_drop`=1; `cnt_sent`=0.
4. **No response.** `recv` never asserted, `RESP_TIMEOUT`=64 → fail taken 64 cycles after each `trig`; request dropped after 4 attempts.
5. **Ack/fail tie and clear.** `ack` and `fail` both high at completion → counted as sent. `clr_cnt` in the same cycle as an increment → both counters 0.
6. **Reset mid-flight.** Assert `rstn`=0 in `WAIT_DONE` with 3 entries queued → outputs at their reset values immediately; `level`=0; no `trig` after release until a new push.

Source files
------------

// File: rtl/irq_req_pkg.sv
// Shared types and helpers for the interrupt request queue.
package irq_req_pkg;

  localparam int unsigned VEC_W = 12;
  localparam int unsigned FNC_W = 8;

  // One queued interrupt request as handed to gen_irq.
  typedef struct packed {
    logic [VEC_W-1:0] vec;
    logic [FNC_W-1:0] fnc;
  } irq_req_t;

  // Issue/response sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RECV,
    WAIT_DONE,
    BACKOFF
  } irq_q_state_t;

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/irq_req_fifo.sv
// Synchronous FIFO of irq_req_t with show-ahead head data.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module irq_req_fifo
  import irq_req_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned PW = AW + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push_i,
  input  irq_req_t      wdata_i,
  input  logic          pop_i,
  output irq_req_t      rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [PW-1:0] level_o
);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  irq_req_t      mem_q [DEPTH];
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // A full FIFO refuses the push even if the head pops in the same cycle.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Next pointer values.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  // Pointer registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array write port.
  // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/irq_req_queue.sv
// Interrupt request queue: buffers {vec, fnc} requests and issues them one
// at a time to gen_irq, retrying failed attempts after a gap and dropping a
// request once its retries are used up. Sent/dropped totals saturate.
module irq_req_queue
  import irq_req_pkg::*;
#(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned RETRY_GAP    = 16,
  parameter int unsigned RESP_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [VEC_W-1:0]       req_vec,
  input  logic [FNC_W-1:0]       req_fnc,
  input  logic                   req_vld,
  output logic                   req_rdy,
  output logic [VEC_W-1:0]       vec,
  output logic [FNC_W-1:0]       fnc,
  output logic                   trig,
  input  logic                   recv,
  input  logic                   ack,
  input  logic                   fail,
  input  logic                   clr_cnt,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic [31:0]            cnt_sent,
  output logic [31:0]            cnt_drop
);

  localparam int unsigned RTRY_W = $clog2(MAX_RETRY + 2);
  localparam int unsigned GAP_W  = $clog2(RETRY_GAP + 1);
  localparam int unsigned TO_W   = $clog2(RESP_TIMEOUT + 1);

  localparam logic [RTRY_W-1:0] RETRY_MAX = RTRY_W'(MAX_RETRY);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(RETRY_GAP - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(RESP_TIMEOUT - 1);

  irq_q_state_t      state_q, state_d;
  irq_req_t          head_q, head_d;
  logic [RTRY_W-1:0] retry_q, retry_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [31:0]       sent_q, sent_d;
  logic [31:0]       drop_q, drop_d;

  logic              fifo_full;
  logic              fifo_empty;
  irq_req_t          fifo_head;
  irq_req_t          push_data;
  logic              pop;
  logic              inc_sent;
  logic              inc_drop;
  logic              attempt_fail;

  assign push_data = '{vec: req_vec, fnc: req_fnc};

  irq_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (req_vld),
    .wdata_i (push_data),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  assign req_rdy  = !fifo_full;
  assign trig     = (state_q == ISSUE);
  assign busy     = (state_q != IDLE);
  assign vec      = head_q.vec;
  assign fnc      = head_q.fnc;
  assign cnt_sent = sent_q;
  assign cnt_drop = drop_q;

  // Sequencer next state plus retry, gap and timeout counter updates.
  always_comb begin
    state_d      = state_q;
    head_d       = head_q;
    retry_d      = retry_q;
    gap_d        = gap_q;
    to_d         = to_q;
    pop          = 1'b0;
    inc_sent     = 1'b0;
    inc_drop     = 1'b0;
    attempt_fail = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          head_d  = fifo_head;
          retry_d = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        to_d    = '0;
        state_d = WAIT_RECV;
      end
      WAIT_RECV: begin
        // ack/fail are leftovers from the previous attempt here; only recv counts.
        if (to_q == TO_LAST) begin
          attempt_fail = 1'b1;
        end else begin
          to_d = to_q + TO_W'(1);
          if (recv) state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!recv && ack) begin
          pop      = 1'b1;
          inc_sent = 1'b1;
          state_d  = IDLE;
        end else if (!recv && fail) begin
          attempt_fail = 1'b1;
        end else if (to_q == TO_LAST) begin
          attempt_fail = 1'b1;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      BACKOFF: begin
        if (gap_q == GAP_LAST) state_d = ISSUE;
        else                   gap_d   = gap_q + GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase

    // A failed or timed-out attempt either re-arms after the gap or drops the request.
    if (attempt_fail) begin
      if (retry_q < RETRY_MAX) begin
        retry_d = retry_q + RTRY_W'(1);
        gap_d   = '0;
        state_d = BACKOFF;
      end else begin
        pop      = 1'b1;
        inc_drop = 1'b1;
        state_d  = IDLE;
      end
    end
  end

  // Status counters: clear has priority over a same-cycle increment.
  always_comb begin
    sent_d = sent_q;
    drop_d = drop_q;
    if (clr_cnt) begin
      sent_d = '0;
      drop_d = '0;
    end else begin
      if (inc_sent) sent_d = sat_inc(sent_q);
      if (inc_drop) drop_d = sat_inc(drop_q);
    end
  end

  // State, held request and counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      head_q  <= '0;
      retry_q <= '0;
      gap_q   <= '0;
      to_q    <= '0;
      sent_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      retry_q <= retry_d;
      gap_q   <= gap_d;
      to_q    <= to_d;
      sent_q  <= sent_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_irq_req_queue.sv
// Directed self-checking bench for irq_req_queue with default parameters.
module tb_irq_req_queue;

  logic        clk;
  logic        rstn;
  logic [11:0] req_vec;
  logic [7:0]  req_fnc;
  logic        req_vld;
  logic        req_rdy;
  logic [11:0] vec;
  logic [7:0]  fnc;
  logic        trig;
  logic        recv;
  logic        ack;
  logic        fail;
  logic        clr_cnt;
  logic [3:0]  level;
  logic        busy;
  logic [31:0] cnt_sent;
  logic [31:0] cnt_drop;

  int checks;
  int errors;
  int cyc;

  irq_req_queue #(
    .DEPTH        (8),
    .MAX_RETRY    (3),
    .RETRY_GAP    (16),
    .RESP_TIMEOUT (64)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .req_vec  (req_vec),
    .req_fnc  (req_fnc),
    .req_vld  (req_vld),
    .req_rdy  (req_rdy),
    .vec      (vec),
    .fnc      (fnc),
    .trig     (trig),
    .recv     (recv),
    .ack      (ack),
    .fail     (fail),
    .clr_cnt  (clr_cnt),
    .level    (level),
    .busy     (busy),
    .cnt_sent (cnt_sent),
    .cnt_drop (cnt_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index: number of rising edges seen so far.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs set and outputs read 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until trig is seen (bounded); returns the cycle index of the pulse.
  task automatic wait_trig(input string tag, output int tc);
    int n;
    n  = 0;
    tc = -1;
    while (trig !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_seen"}, 32'(trig), 32'd1);
    if (trig === 1'b1) tc = cyc;
  endtask

  // Called in the trig cycle (or later in WAIT_RECV): hold recv for recv_cycles
  // edges, then drop recv with the given ack/fail levels for one completion edge.
  // Returns the completion cycle index.
  task automatic serve(input int recv_cycles, input logic a, input logic f,
                       input logic clr, output int done_cyc);
    recv = 1'b1;
    ack  = 1'b0;
    fail = 1'b0;
    tick();
    check("trig_one_cycle", 32'(trig), 32'd0);
    repeat (recv_cycles - 1) tick();
    recv     = 1'b0;
    ack      = a;
    fail     = f;
    clr_cnt  = clr;
    done_cyc = cyc;
    tick();
    clr_cnt = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_trig"},    32'(trig),    32'd0);
    check({pfx, "_vec"},     32'(vec),     32'd0);
    check({pfx, "_fnc"},     32'(fnc),     32'd0);
    check({pfx, "_busy"},    32'(busy),    32'd0);
    check({pfx, "_level"},   32'(level),   32'd0);
    check({pfx, "_sent"},    cnt_sent,     32'd0);
    check({pfx, "_drop"},    cnt_drop,     32'd0);
    check({pfx, "_req_rdy"}, 32'(req_rdy), 32'd1);
  endtask

  initial begin
    int pc, tc, mc, fc, ntrig;
    logic [11:0] exp_vec;
    logic [7:0]  exp_fnc;

    checks  = 0;
    errors  = 0;
    rstn    = 1'b0;
    req_vec = '0;
    req_fnc = '0;
    req_vld = 1'b0;
    recv    = 1'b0;
    ack     = 1'b0;
    fail    = 1'b0;
    clr_cnt = 1'b0;

    repeat (3) tick();
    check_reset_outputs("rst");
    rstn = 1'b1;
    tick();

    // ---- 1: single request, prompt ack ----
    req_vec = 12'h005;
    req_fnc = 8'h01;
    req_vld = 1'b1;
    pc      = cyc;
    tick();
    req_vld = 1'b0;
    check("t1_level_after_push", 32'(level), 32'd1);
    wait_trig("t1_trig", tc);
    check("t1_latency", 32'(tc), 32'(pc + 2));
    check("t1_vec", 32'(vec), 32'h005);
    check("t1_fnc", 32'(fnc), 32'h01);
    serve(3, 1'b1, 1'b0, 1'b0, mc);
    check("t1_sent", cnt_sent, 32'd1);
    check("t1_drop", cnt_drop, 32'd0);
    check("t1_level", 32'(level), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);

    // ---- 2: full FIFO, issue order ----
    ack = 1'b0;
    for (int i = 0; i < 9; i++) begin
      req_vec = 12'h100 + 12'(i);
      req_fnc = 8'h10 + 8'(i);
      req_vld = 1'b1;
      check($sformatf("t2_rdy_%0d", i), 32'(req_rdy), (i < 8) ? 32'd1 : 32'd0);
      tick();
    end
    req_vld = 1'b0;
    check("t2_level_full", 32'(level), 32'd8);
    check("t2_rdy_full", 32'(req_rdy), 32'd0);
    check("t2_busy", 32'(busy), 32'd1);
    // Entry 0 was issued during the push burst and sits in WAIT_RECV.
    check("t2_vec_0", 32'(vec), 32'h100);
    check("t2_fnc_0", 32'(fnc), 32'h10);
    serve(2, 1'b1, 1'b0, 1'b0, mc);
    for (int i = 1; i < 8; i++) begin
      wait_trig($sformatf("t2_trig_%0d", i), tc);
      if (i == 1) check("t2_back_to_back", 32'(tc), 32'(mc + 2));
      check($sformatf("t2_vec_%0d", i), 32'(vec), 32'h100 + 32'(i));
      check($sformatf("t2_fnc_%0d", i), 32'(fnc), 32'h10 + 32'(i));
      serve(2, 1'b1, 1'b0, 1'b0, mc);
    end
    ack = 1'b0;
    repeat (5) tick();
    check("t2_sent", cnt_sent, 32'd9);
    check("t2_level_empty", 32'(level), 32'd0);
    check("t2_idle", 32'(busy), 32'd0);

    // ---- 3: retries exhausted ----
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("t3_clr_sent", cnt_sent, 32'd0);
    req_vec = 12'h3AA;
    req_fnc = 8'h33;
    req_vld = 1'b1;
    tick();
    req_vld = 1'b0;
    wait_trig("t3_trig_0", tc);
    for (int a = 0; a < 4; a++) begin
      check($sformatf("t3_vec_%0d", a), 32'(vec), 32'h3AA);
      serve(2, 1'b0, 1'b1, 1'b0, fc);
      if (a < 3) begin
        check($sformatf("t3_backoff_busy_%0d", a), 32'(busy), 32'd1);
        wait_trig($sformatf("t3_trig_%0d", a + 1), tc);
        check($sformatf("t3_spacing_%0d", a + 1), 32'(tc), 32'(fc + 17));
      end
    end
    fail = 1'b0;
    check("t3_drop", cnt_drop, 32'd1);
    check("t3_sent", cnt_sent, 32'd0);
    check("t3_level", 32'(level), 32'd0);
    check("t3_idle", 32'(busy), 32'd0);

    // ---- 4: no response, timeout on every attempt ----
    ack  = 1'b0;
    fail = 1'b0;
    recv = 1'b0;
    req_vec = 12'h444;
    req_fnc = 8'h44;
    req_vld = 1'b1;
    tick();
    req_vld = 1'b0;
    wait_trig("t4_trig_0", tc);
    for (int a = 1; a < 4; a++) begin
      pc = tc;
      tick();
      wait_trig($sformatf("t4_trig_%0d", a), tc);
      check($sformatf("t4_spacing_%0d", a), 32'(tc), 32'(pc + 64 + 17));
    end
    repeat (64) tick();
    check("t4_busy_at_timeout", 32'(busy), 32'd1);
    check("t4_drop_before", cnt_drop, 32'd1);
    tick();
    check("t4_drop_after", cnt_drop, 32'd2);
    check("t4_idle", 32'(busy), 32'd0);
    check("t4_level", 32'(level), 32'd0);

    // ---- 5: ack/fail tie counts as sent; clear beats increment ----
    req_vec = 12'h555;
    req_fnc = 8'h55;
    req_vld = 1'b1;
    tick();
    req_vld = 1'b0;
    wait_trig("t5_trig_tie", tc);
    serve(2, 1'b1, 1'b1, 1'b0, mc);
    check("t5_tie_sent", cnt_sent, 32'd1);
    check("t5_tie_drop", cnt_drop, 32'd2);
    check("t5_tie_idle", 32'(busy), 32'd0);
    req_vec = 12'h556;
    req_fnc = 8'h56;
    req_vld = 1'b1;
    tick();
    req_vld = 1'b0;
    wait_trig("t5_trig_clr", tc);
    serve(2, 1'b1, 1'b0, 1'b1, mc);
    check("t5_clr_sent", cnt_sent, 32'd0);
    check("t5_clr_drop", cnt_drop, 32'd0);

    // ---- 6: reset mid-flight with entries queued ----
    ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_vec = 12'h600 + 12'(i);
      req_fnc = 8'h60 + 8'(i);
      req_vld = 1'b1;
      tick();
    end
    req_vld = 1'b0;
    serve(2, 1'b1, 1'b0, 1'b0, mc);
    wait_trig("t6_trig_1", tc);
    recv = 1'b1;
    ack  = 1'b0;
    tick();
    tick();
    check("t6_pre_busy", 32'(busy), 32'd1);
    check("t6_pre_level", 32'(level), 32'd3);
    check("t6_pre_sent", cnt_sent, 32'd1);
    check("t6_pre_vec", 32'(vec), 32'h601);
    #2;
    rstn = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    recv = 1'b0;
    tick();
    rstn  = 1'b1;
    ntrig = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (trig === 1'b1) ntrig++;
    end
    check("t6_no_trig", 32'(ntrig), 32'd0);
    check("t6_level_post", 32'(level), 32'd0);
    exp_vec = 12'h7C1;
    exp_fnc = 8'h7C;
    req_vec = exp_vec;
    req_fnc = exp_fnc;
    req_vld = 1'b1;
    pc      = cyc;
    tick();
    req_vld = 1'b0;
    wait_trig("t6_trig_new", tc);
    check("t6_new_latency", 32'(tc), 32'(pc + 2));
    check("t6_new_vec", 32'(vec), 32'(exp_vec));
    check("t6_new_fnc", 32'(fnc), 32'(exp_fnc));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
